// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter and response router for a shared single-port memory
//
// Build option: MEM_ARB_PERF_EN builds the saturating performance counters.
// Without it, cnt_conflict and cnt_if_stall are tied to 0.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   if_req/if_addr    fetch request and byte address
//   if_gnt/if_stall   fetch granted / fetch blocked this cycle
//   if_valid/if_rdata fetch response, one cycle after the grant
//   d_req/d_we/d_be   data request, store select, store byte enables
//   d_addr/d_wdata    data byte address and lane-aligned store data
//   d_gnt             data granted this cycle
//   d_valid/d_rdata   load data or store acknowledge (rdata 0), one cycle after the grant
//   mem_*             memory command; mem_rdata is registered inside the memory
//   cnt_conflict      cycles where both ports requested
//   cnt_if_stall      cycles where fetch was stalled
module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [CNT_W-1:0]  cnt_conflict,
  output logic [CNT_W-1:0]  cnt_if_stall
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESP_IF   = 2'd1,
    RESP_D_RD = 2'd2,
    RESP_D_WR = 2'd3
  } state_t;

  state_t state, next_state;

  // Byte-offset bits are the requester's concern; they never reach the memory.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, if_addr[1:0], d_addr[1:0]};

  // Grant and memory command. Grants are masked while reset is held so the
  // memory sees no traffic during reset.
  always_comb begin
    d_gnt     = 1'b0;
    if_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (rst) begin
      d_gnt  = d_req;
      if_gnt = if_req & ~d_req;
    end
    if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr[ADDR_W-1:2];
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr[ADDR_W-1:2];
    end
  end

  assign if_stall = if_req & ~if_gnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The state records who owns the word coming out of the memory next cycle.
  // Response outputs are also masked by rst so an access in flight when reset
  // arrives never produces a valid pulse.
  always_comb begin
    next_state = IDLE;
    if_valid   = 1'b0;
    if_rdata   = 32'h0;
    d_valid    = 1'b0;
    d_rdata    = 32'h0;

    if (d_gnt) begin
      next_state = d_we ? RESP_D_WR : RESP_D_RD;
    end else if (if_gnt) begin
      next_state = RESP_IF;
    end

    if (rst) begin
      case (state)
        RESP_IF: begin
          if_valid = 1'b1;
          if_rdata = mem_rdata;
        end
        RESP_D_RD: begin
          d_valid = 1'b1;
          d_rdata = mem_rdata;
        end
        RESP_D_WR: begin
          d_valid = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [CNT_W-1:0] conflict_q;
  logic [CNT_W-1:0] stall_q;

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      conflict_q <= '0;
      stall_q    <= '0;
    end else begin
      if (if_req && d_req && (conflict_q != {CNT_W{1'b1}})) begin
        conflict_q <= conflict_q + 1'b1;
      end
      if (if_stall && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign cnt_conflict = conflict_q;
  assign cnt_if_stall = stall_q;
`else
  assign cnt_conflict = '0;
  assign cnt_if_stall = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 4;
  localparam int WORDS  = 64;
  localparam int CMAX   = 15;

  logic              clk;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [31:0]       if_rdata;
  logic              if_stall;
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [31:0]       d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic [CNT_W-1:0]  cnt_conflict;
  logic [CNT_W-1:0]  cnt_if_stall;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cnt_conflict(cnt_conflict), .cnt_if_stall(cnt_if_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory attached to the DUT command port: registered read, byte-masked write.
  logic [31:0] mem [WORDS];
  logic [31:0] rd_q;
  assign mem_rdata = rd_q;
  always @(posedge clk) begin
    if (mem_en) begin
      rd_q <= mem[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we && mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // Reference: memory contents as implied by the accepted requests.
  logic [31:0] ref_mem [WORDS];

  typedef struct {
    int          due;
    bit          is_if;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int m_conf  = 0;
  int m_stall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the expected response whenever the DUT presents one.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due < cyc) begin
      chk("missing_response", 32'd0, 32'd1);
      void'(q.pop_front());
    end
    if (if_valid || d_valid) begin
      chk("one_valid_at_a_time", {31'd0, if_valid & d_valid}, 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_response", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_cycle", cyc, e.due);
        chk("resp_port_is_if", {31'd0, if_valid}, {31'd0, e.is_if});
        chk("resp_data", if_valid ? if_rdata : d_rdata, e.data);
      end
    end else begin
      chk("idle_rdata", if_rdata | d_rdata, 32'd0);
    end
  end

  // One cycle of stimulus: drive, check the combinational command at the
  // falling edge, then record the expected response and counter effects.
  task automatic step(input logic r, input logic ir, input logic [7:0] ia,
                      input logic dr, input logic dw, input logic [3:0] be,
                      input logic [7:0] da, input logic [31:0] wd);
    logic eg_d, eg_i;
    logic [5:0] w;
    rst = r; if_req = ir; if_addr = ia;
    d_req = dr; d_we = dw; d_be = be; d_addr = da; d_wdata = wd;
    if (!r) q.delete();
    @(negedge clk);
    eg_d = r & dr;
    eg_i = r & ir & ~dr;
    chk("d_gnt", {31'd0, d_gnt}, {31'd0, eg_d});
    chk("if_gnt", {31'd0, if_gnt}, {31'd0, eg_i});
    chk("if_stall", {31'd0, if_stall}, {31'd0, ir & ~eg_i});
    chk("mem_en", {31'd0, mem_en}, {31'd0, eg_d | eg_i});
    chk("mem_we", {31'd0, mem_we}, {31'd0, eg_d & dw});
    chk("mem_be", {28'd0, mem_be}, {28'd0, eg_d ? be : 4'b0000});
    chk("mem_addr", {26'd0, mem_addr}, eg_d ? {26'd0, da[7:2]} : (eg_i ? {26'd0, ia[7:2]} : 32'd0));
    chk("mem_wdata", mem_wdata, eg_d ? wd : 32'd0);
    chk("cnt_conflict", {28'd0, cnt_conflict}, m_conf);
    chk("cnt_if_stall", {28'd0, cnt_if_stall}, m_stall);
    if (!r) begin
      chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_rdata", if_rdata | d_rdata, 32'd0);
    end
    if (eg_d) begin
      w = da[7:2];
      if (dw) begin
        q.push_back('{due: cyc + 1, is_if: 1'b0, data: 32'd0});
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
      end else begin
        q.push_back('{due: cyc + 1, is_if: 1'b0, data: ref_mem[w]});
      end
    end else if (eg_i) begin
      w = ia[7:2];
      q.push_back('{due: cyc + 1, is_if: 1'b1, data: ref_mem[w]});
    end
`ifdef MEM_ARB_PERF_EN
    if (!r) begin
      m_conf = 0; m_stall = 0;
    end else begin
      if (ir && dr && m_conf < CMAX) m_conf++;
      if (ir && dr && m_stall < CMAX) m_stall++;
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic r);
    step(r, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
  endtask

  initial begin
    logic       p_ir;
    logic [7:0] p_ia;
    logic       r, ir, dr, dw;
    logic [7:0] ia, da;
    logic [3:0] be;
    logic [31:0] wd;
    for (int k = 0; k < WORDS; k++) begin
      mem[k] = 32'h1000 + k;
      ref_mem[k] = 32'h1000 + k;
    end
    rd_q = 32'h0;
    rst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_be = '0; d_addr = '0; d_wdata = '0;
    @(posedge clk); #1;

    // Reset with both ports requesting: nothing granted, nothing returned.
    step(1'b0, 1'b1, 8'h04, 1'b1, 1'b0, 4'h0, 8'h08, 32'h0);
    step(1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 4'h0, 8'h08, 32'h0);

    // Fetch-only sequence.
    step(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    step(1'b1, 1'b1, 8'h04, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    step(1'b1, 1'b1, 8'h08, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    idle(1'b1);

    // Conflict: load wins, fetch held and granted the next cycle.
    idle(1'b0);
    step(1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 4'h0, 8'h20, 32'h0);
    step(1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    idle(1'b1);
`ifdef MEM_ARB_PERF_EN
    chk("conflict_once", {28'd0, cnt_conflict}, 32'd1);
    chk("stall_once", {28'd0, cnt_if_stall}, 32'd1);
`else
    chk("conflict_off", {28'd0, cnt_conflict}, 32'd0);
`endif

    // Store of the low half, then load it back with unaligned low bits.
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 4'b0011, 8'h30, 32'hDEADBEEF);
    idle(1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 4'b0000, 8'h33, 32'h0);
    idle(1'b1);
    chk("store_merge_ref", ref_mem[12], 32'h0000BEEF);

    // Reset arrives while a fetch response is in flight.
    step(1'b1, 1'b1, 8'h14, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    step(1'b0, 1'b1, 8'h14, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    step(1'b0, 1'b1, 8'h14, 1'b1, 1'b1, 4'hF, 8'h14, 32'h12345678);

    // Saturation: 20 conflict cycles.
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b1, 8'h18, 1'b1, 1'b0, 4'h0, 8'(4 * i), 32'h0);
    idle(1'b1);
`ifdef MEM_ARB_PERF_EN
    chk("conflict_sat", {28'd0, cnt_conflict}, 32'd15);
    chk("stall_sat", {28'd0, cnt_if_stall}, 32'd15);
`else
    chk("conflict_off_sat", {28'd0, cnt_conflict}, 32'd0);
    chk("stall_off_sat", {28'd0, cnt_if_stall}, 32'd0);
`endif

    // Randomized traffic; a stalled fetch is usually held, sometimes dropped.
    p_ir = 1'b0; p_ia = 8'h00;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 99) != 0);
      if (p_ir && $urandom_range(0, 7) != 0) begin
        ir = 1'b1; ia = p_ia;
      end else begin
        ir = ($urandom_range(0, 3) != 0);
        ia = 8'($urandom);
      end
      dr = ($urandom_range(0, 9) < 4);
      dw = $urandom_range(0, 1) == 1;
      be = 4'($urandom);
      da = 8'($urandom);
      wd = $urandom;
      step(r, ir, ia, dr, dw, be, da, wd);
      p_ir = ir & ~(r & ~dr);
      p_ia = ia;
    end
    idle(1'b1);
    idle(1'b1);
    chk("queue_drained", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that lets the instruction-fetch stage and the load/store stage share one single-ported, synchronous-read unified memory. Each cycle it grants exactly one requester, with the data port taking priority. It drives the memory command and returns each read response to the port that issued it, one cycle later. It also produces the fetch stall signal that the pipeline uses to freeze the PC and the IF/ID register on a structural hazard.

## Interface
Parameters:
- ADDR_W, 8, byte-address width; memory word address is addr[ADDR_W-1:2]
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  clock; everything is sampled on the rising edge
- rst  in  1  reset, synchronous and active-low
- if_req  in  1  fetch request; held until granted
- if_addr  in  ADDR_W  fetch byte address
- if_gnt  out  1  fetch granted this cycle
- if_valid  out  1  fetch response valid
- if_rdata  out  32  fetched instruction
- if_stall  out  1  if_req & ~if_gnt
- d_req  in  1  data request; held until granted
- d_we  in  1  1 = store, 0 = load
- d_be  in  4  store byte enables
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  32  store data, already lane-aligned
- d_gnt  out  1  data granted this cycle
- d_valid  out  1  data response or store acknowledge
- d_rdata  out  32  load data; 0 on a store acknowledge
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_be  out  4  memory byte enables
- mem_addr  out  ADDR_W-2  memory word address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, registered inside the memory (valid the cycle after mem_en)
- cnt_conflict  out  CNT_W  cycles in which both ports requested
- cnt_if_stall  out  CNT_W  cycles with if_stall = 1

## Operation
- Grant logic is combinational from the current requests.
  - d_gnt = d_req.
  - if_gnt = if_req & ~d_req.
- Memory command follows the grant in the same cycle:
  - mem_en = d_gnt | if_gnt.
  - When the data port is granted: mem_we = d_we, mem_be = d_be, mem_addr = d_addr[ADDR_W-1:2], mem_wdata = d_wdata.
  - When the fetch port is granted: mem_we = 0, mem_be = 4'b0000, mem_addr = if_addr[ADDR_W-1:2], mem_wdata = 0.
  - When neither is granted: all memory command outputs are 0.
- Response tracking uses a registered state machine with states IDLE, RESP_IF, RESP_D_RD and RESP_D_WR.
  - The next state is chosen from the grant issued in the current cycle: data load → RESP_D_RD, data store → RESP_D_WR, fetch → RESP_IF, no grant → IDLE.
  - Any state can move to any other state every cycle, so back-to-back accesses have no bubble.
- Outputs per state:
  - RESP_IF: if_valid = 1, if_rdata = mem_rdata.
  - RESP_D_RD: d_valid = 1, d_rdata = mem_rdata.
  - RESP_D_WR: d_valid = 1, d_rdata = 0.
  - In every other case the valid outputs are 0 and the rdata outputs are 0.
- Low address bits: addr[1:0] are ignored. Alignment is the requester's responsibility.
- Simultaneous requests: the data port wins. The fetch port sees if_stall = 1 and must hold if_req and if_addr until granted.
- A request dropped before it is granted is legal and leaves no trace.

## Timing
- Grant latency: 0 cycles (same cycle as the request).
- Response latency: exactly 1 cycle after the grant.
- Throughput: 1 access per cycle in total.
- Reset (rst = 0 at a clock edge):
  - The state goes to IDLE.
  - if_valid, d_valid, if_rdata and d_rdata read 0 from the next cycle onward, for as long as rst stays low.
  - Counters clear to 0.
- Reset while an access is in flight: the response is discarded and no valid pulse is produced.
- While rst is low, the grant outputs and mem_en are forced to 0.
- Counters saturate at all-ones; they do not wrap.

## Configuration
- MEM_ARB_PERF_EN defined:
  - cnt_conflict increments in each cycle where if_req & d_req.
  - cnt_if_stall increments in each cycle where if_stall.
  - Both counters saturate at all-ones.
- MEM_ARB_PERF_EN undefined: no counter registers are built, and both counter outputs are constant 0. The ports are present in both builds.

## Test plan
- Fetch-only sequence: if_req = 1 with addresses 0x00, 0x04, 0x08 on consecutive cycles and memory word k preloaded with 0x1000+k → if_gnt = 1 every cycle, if_valid = 1 from cycle 1 onward with if_rdata = 0x1000, 0x1001, 0x1002, and d_valid stays 0.
- Conflict: if_req = 1 with if_addr = 0x10, plus d_req = 1 as a load from 0x20 for one cycle → d_gnt = 1 and if_stall = 1 in cycle 0; d_valid = 1 with d_rdata = word 8 in cycle 1; if_gnt = 1 in cycle 1; if_valid = 1 with word 4 in cycle 2; cnt_conflict = 1 and cnt_if_stall = 1.
- Store: d_req = 1, d_we = 1, d_be = 4'b0011, d_addr = 0x30, d_wdata = 0xDEADBEEF → mem_we = 1, mem_be = 4'b0011, mem_addr = 12; the next cycle d_valid = 1 with d_rdata = 0; a later load from 0x30 returns the upper bytes unchanged and the lower half as 0xBEEF.
- Reset mid-flight: grant a fetch, then drive rst = 0 on the next edge → if_valid = 0, if_rdata = 0, counters = 0, and grants stay 0 while rst is low.
- Saturation with MEM_ARB_PERF_EN and CNT_W = 4: 20 conflict cycles → cnt_conflict = 15. The same run without the macro gives both counters = 0.
